grad_central_diff: RTL and testbench
====================================

Name: grad_central_diff

Overview:
- Sequencing stage that sits directly downstream of the function evaluator (x^2 + 4x - 1, Q.8 fixed point) and drives it.
- Computes a central-difference gradient g(x) = (f(x+h) - f(x-h)) / (2h) for the optimiser loop.
- Owns the evaluator's start/done handshake: issues two evaluations back to back, then combines the results.
- h is a power of two, so the division reduces to a shift.

Parameters:
- FRAC_BITS, 8: fractional bits of x (Q24.8) and f/grad (Q56.8).
- H_SHIFT, 4: h = 2^H_SHIFT raw LSBs (default h = 1/16). Legal range 0..FRAC_BITS-1; elaboration error otherwise.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start_grad  in  1  level request; held high until grad_done is seen.
- x_in  in  32  signed Q24.8 evaluation point; sampled in IDLE when start_grad=1.
- grad_out  out  64  signed Q56.8 gradient; valid while grad_done=1.
- grad_done  out  1  result valid; held until start_grad drops.
- overflow  out  1  sticky per operation; valid with grad_done.
- func_start  out  1  to evaluator start_func.
- func_x  out  32  to evaluator x_in.
- func_y  in  64  from evaluator y_out.
- func_done  in  1  from evaluator func_done.
- func_ovf  in  1  from evaluator overflow.

Behaviour:
- Reset (async, rst=1), all registered:
  - grad_out=0, grad_done=0, overflow=0, func_start=0, func_x=0, state=IDLE.
  - Applies mid-operation too: func_start drops immediately and the evaluator is left to return to its idle state by its own handshake.
- State IDLE: grad_done=0.
  - On start_grad=1: latch x_in; compute xp=x+h and xm=x-h with 32-bit wrap.
  - overflow <= signed-overflow(xp) | signed-overflow(xm); all other overflow sources are cleared.
  - Go to EVAL_P.
- State EVAL_P: func_x=xp, func_start=1. Wait for func_done=1, then capture fp<=func_y, overflow|=func_ovf, go to REL_P.
- State REL_P: func_start=0. Wait for func_done=0, because the evaluator holds done high for 1-2 cycles after start drops. Then go to EVAL_M.
- State EVAL_M / REL_M: same as EVAL_P / REL_P, using xm and capturing fm.
- State CALC (1 cycle):
  - d = fp - fm, 65-bit signed.
  - grad_out <= d <<< (FRAC_BITS-H_SHIFT-1), truncated to 64 bits.
  - overflow |= (d does not fit in 64 bits) | (shifted value does not fit in 64 bits).
  - Go to DONE.
- State DONE: grad_done=1, grad_out held. When start_grad=0, go to IDLE; grad_done falls the cycle after.
- Holding behaviour:
  - func_x is stable for the entire time func_start=1.
  - func_start is never re-asserted while func_done=1.
  - No new evaluation is started while start_grad stays high in DONE.
- Latency: grad_done rises 2 cycles after REL_M exits (CALC, then DONE register).
- start_grad dropping before DONE: ignored. The operation completes; DONE is then left on the next cycle and grad_done pulses for 1 cycle.
- Overflow does not abort the operation. grad_out still carries the wrapped result.
- Central difference is exact for quadratics in exact arithmetic. Q.8 truncation of x^2 inside the evaluator may cause ±1 LSB error before the shift.

Test Plan:
- x_in=256 (1.0), defaults: fp=1121, fm=929 -> grad_out=1536 (6.0), overflow=0, exactly 2 func_start pulses.
- x_in=0: fp=-191, fm=-319 -> grad_out=1024 (4.0), overflow=0.
- x_in=-512 (-2.0): fp=fm=-1279 -> grad_out=0, overflow=0.
- x_in=32'h7FFFFFF8: x+h wraps -> overflow=1, grad_done still asserted, no hang.
- Handshake: hold start_grad 5 cycles after grad_done -> grad_done stays 1, func_start stays 0, grad_out constant. Drop start_grad -> grad_done=0 one cycle later. Re-raise start_grad -> fresh evaluation.
- Reset: assert rst while in EVAL_M -> outputs 0 in the same cycle. Release rst, wait for the evaluator's func_done=0, start with x_in=256 -> grad_out=1536.

Source files
------------

// File: rtl/grad_central_diff.sv
// Central-difference gradient sequencer: drives the f(x) evaluator twice
// (at x+h and x-h) and forms (f(x+h) - f(x-h)) / (2h) as a shift.
module grad_central_diff #(
    parameter int FRAC_BITS = 8,
    parameter int H_SHIFT   = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_grad,
    input  logic signed [31:0] x_in,
    output logic signed [63:0] grad_out,
    output logic               grad_done,
    output logic               overflow,
    output logic               func_start,
    output logic signed [31:0] func_x,
    input  logic signed [63:0] func_y,
    input  logic               func_done,
    input  logic               func_ovf
);

    // h must be strictly finer than one integer unit so the shift is >= 0
    generate
        if (H_SHIFT < 0 || H_SHIFT > FRAC_BITS - 1) begin : g_bad_h
            $error("grad_central_diff: H_SHIFT must be in 0..FRAC_BITS-1");
        end
    endgenerate

    // (fp - fm) / (2h) in Q.FRAC_BITS == d << (FRAC_BITS - H_SHIFT - 1)
    localparam int          SH = FRAC_BITS - H_SHIFT - 1;
    localparam int          SW = 65 + SH;
    localparam logic [31:0] H  = 32'd1 << H_SHIFT;

    typedef enum logic [2:0] {
        IDLE, EVAL_P, REL_P, EVAL_M, REL_M, CALC, DONE
    } state_t;

    state_t             state_q, state_d;
    logic signed [31:0] xp_q, xp_d;
    logic signed [31:0] xm_q, xm_d;
    logic signed [63:0] fp_q, fp_d;
    logic signed [63:0] fm_q, fm_d;
    logic signed [63:0] grad_q, grad_d;
    logic               done_q, done_d;
    logic               ovf_q, ovf_d;
    logic               fstart_q, fstart_d;
    logic signed [31:0] fx_q, fx_d;

    logic signed [31:0] xp, xm;
    logic               ovf_xp, ovf_xm;
    logic signed [64:0] diff;
    logic signed [SW-1:0] diff_ext, diff_sh;
    logic               diff_fit, sh_fit;

    // Offset points and final difference, always computed; used by the FSM
    always_comb begin
        xp       = x_in + H;
        xm       = x_in - H;
        // h > 0: x+h can only wrap upward from non-negative, x-h downward from negative
        ovf_xp   = ~x_in[31] & xp[31];
        ovf_xm   = x_in[31] & ~xm[31];
        diff     = {fp_q[63], fp_q} - {fm_q[63], fm_q};
        diff_ext = SW'(diff);
        diff_sh  = diff_ext <<< SH;
        diff_fit = (diff[64] == diff[63]);
        sh_fit   = (&diff_sh[SW-1:63]) | ~(|diff_sh[SW-1:63]);
    end

    // Sequencer: next-state and next-value of every registered output
    always_comb begin
        state_d  = state_q;
        xp_d     = xp_q;
        xm_d     = xm_q;
        fp_d     = fp_q;
        fm_d     = fm_q;
        grad_d   = grad_q;
        done_d   = done_q;
        ovf_d    = ovf_q;
        fstart_d = fstart_q;
        fx_d     = fx_q;
        case (state_q)
            IDLE: begin
                done_d = 1'b0;
                if (start_grad) begin
                    xp_d     = xp;
                    xm_d     = xm;
                    ovf_d    = ovf_xp | ovf_xm;
                    fx_d     = xp;
                    fstart_d = 1'b1;
                    state_d  = EVAL_P;
                end
            end
            EVAL_P: begin
                if (func_done) begin
                    fp_d     = func_y;
                    ovf_d    = ovf_q | func_ovf;
                    fstart_d = 1'b0;
                    state_d  = REL_P;
                end
            end
            // Evaluator keeps done high briefly after start drops; wait it out
            // so the next start is never raised on top of a stale done.
            REL_P: begin
                if (!func_done) begin
                    fx_d     = xm_q;
                    fstart_d = 1'b1;
                    state_d  = EVAL_M;
                end
            end
            EVAL_M: begin
                if (func_done) begin
                    fm_d     = func_y;
                    ovf_d    = ovf_q | func_ovf;
                    fstart_d = 1'b0;
                    state_d  = REL_M;
                end
            end
            REL_M: begin
                if (!func_done) state_d = CALC;
            end
            CALC: begin
                grad_d  = diff_sh[63:0];
                ovf_d   = ovf_q | ~diff_fit | ~sh_fit;
                done_d  = 1'b1;
                state_d = DONE;
            end
            DONE: begin
                if (!start_grad) begin
                    done_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                fstart_d = 1'b0;
                done_d   = 1'b0;
                state_d  = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset drops the evaluator request at once
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            xp_q     <= '0;
            xm_q     <= '0;
            fp_q     <= '0;
            fm_q     <= '0;
            grad_q   <= '0;
            done_q   <= 1'b0;
            ovf_q    <= 1'b0;
            fstart_q <= 1'b0;
            fx_q     <= '0;
        end else begin
            state_q  <= state_d;
            xp_q     <= xp_d;
            xm_q     <= xm_d;
            fp_q     <= fp_d;
            fm_q     <= fm_d;
            grad_q   <= grad_d;
            done_q   <= done_d;
            ovf_q    <= ovf_d;
            fstart_q <= fstart_d;
            fx_q     <= fx_d;
        end
    end

    assign grad_out   = grad_q;
    assign grad_done  = done_q;
    assign overflow   = ovf_q;
    assign func_start = fstart_q;
    assign func_x     = fx_q;

endmodule

// File: tb/tb_grad_central_diff.sv
// Bench for grad_central_diff with a behavioural x^2+4x-1 evaluator.
module tb_grad_central_diff;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               start_grad = 1'b0;
    logic signed [31:0] x_in = '0;
    logic signed [63:0] grad_out;
    logic               grad_done, overflow, func_start;
    logic signed [31:0] func_x;
    logic signed [63:0] func_y = '0;
    logic               func_done = 1'b0;
    logic               func_ovf = 1'b0;

    int checks = 0;
    int errors = 0;

    grad_central_diff #(.FRAC_BITS(8), .H_SHIFT(4)) dut (
        .clk(clk), .rst(rst), .start_grad(start_grad), .x_in(x_in),
        .grad_out(grad_out), .grad_done(grad_done), .overflow(overflow),
        .func_start(func_start), .func_x(func_x), .func_y(func_y),
        .func_done(func_done), .func_ovf(func_ovf)
    );

    always #5 clk = ~clk;

    // Evaluator model: 3-cycle compute, done held while start is high,
    // then 1 or 2 extra cycles of done after start drops.
    logic   ev_force_ovf = 1'b0;
    int     ev_st = 0, ev_cnt = 0;
    logic   ev_hold2 = 1'b0;
    longint ev_xs;
    always @(posedge clk) begin
        case (ev_st)
            0: if (func_start) begin ev_cnt <= 2; ev_st <= 1; end
            1: if (ev_cnt == 0) begin
                   ev_xs      = longint'(func_x);
                   func_y    <= ((ev_xs * ev_xs) >>> 8) + 4 * ev_xs - 256;
                   func_ovf  <= ev_force_ovf;
                   func_done <= 1'b1;
                   ev_st     <= 2;
               end else ev_cnt <= ev_cnt - 1;
            2: if (!func_start) begin
                   ev_cnt   <= ev_hold2 ? 1 : 0;
                   ev_hold2 <= ~ev_hold2;
                   ev_st    <= 3;
               end
            default: if (ev_cnt == 0) begin func_done <= 1'b0; ev_st <= 0; end
                     else ev_cnt <= ev_cnt - 1;
        endcase
    end

    // Protocol monitor: count start pulses, flag unstable func_x and
    // start raised on top of done.
    int                 pulses = 0;
    int                 viol = 0;
    logic               prev_start = 1'b0;
    logic signed [31:0] prev_x = '0;
    always @(negedge clk) begin
        if (func_start && !prev_start) begin
            pulses <= pulses + 1;
            if (func_done) viol <= viol + 1;
        end
        if (func_start && prev_start && func_x != prev_x) viol <= viol + 1;
        prev_start <= func_start;
        prev_x     <= func_x;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Start one gradient, wait (bounded) for grad_done; start_grad left high
    task automatic run_op(input logic [31:0] x, input logic fo,
                          output logic [63:0] g, output logic ov,
                          output int np, output logic ok);
        int snap;
        @(negedge clk);
        x_in = x; ev_force_ovf = fo; snap = pulses; start_grad = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (grad_done) begin ok = 1'b1; break; end
        end
        g = grad_out; ov = overflow; np = pulses - snap;
    endtask

    typedef struct {
        logic [31:0] x;
        logic        fo;
        logic [63:0] exp_g;
        logic        chk_g;
        logic        exp_ov;
    } vec_t;

    vec_t        vecs[7];
    logic [63:0] g;
    logic        ov, ok;
    int          np;

    initial begin
        vecs[0] = '{32'd256,        1'b0, 64'd1536, 1'b1, 1'b0};
        vecs[1] = '{32'd0,          1'b0, 64'd1024, 1'b1, 1'b0};
        vecs[2] = '{-32'sd512,      1'b0, 64'd0,    1'b1, 1'b0};
        vecs[3] = '{-32'sd256,      1'b0, 64'd512,  1'b1, 1'b0};
        vecs[4] = '{32'h7FFFFFF8,   1'b0, 64'd0,    1'b0, 1'b1};
        vecs[5] = '{32'd256,        1'b1, 64'd1536, 1'b1, 1'b1};
        vecs[6] = '{32'h80000004,   1'b0, 64'd0,    1'b0, 1'b1};

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_grad_done", 64'(grad_done), 64'd0);
        chk("rst_func_start", 64'(func_start), 64'd0);
        chk("rst_grad_out", grad_out, 64'd0);
        chk("rst_overflow", 64'(overflow), 64'd0);
        chk("rst_func_x", 64'(func_x), 64'd0);
        rst = 1'b0;

        // Table: each vector followed by release and overflow-clear via next vector
        for (int i = 0; i < 7; i++) begin
            run_op(vecs[i].x, vecs[i].fo, g, ov, np, ok);
            chk($sformatf("v%0d_done", i), 64'(ok), 64'd1);
            if (vecs[i].chk_g) chk($sformatf("v%0d_grad", i), g, vecs[i].exp_g);
            chk($sformatf("v%0d_ovf", i), 64'(ov), 64'(vecs[i].exp_ov));
            chk($sformatf("v%0d_pulses", i), 64'(np), 64'd2);
            start_grad = 1'b0;
            @(negedge clk);
            chk($sformatf("v%0d_release", i), 64'(grad_done), 64'd0);
        end
        ev_force_ovf = 1'b0;

        // Hold start_grad after done: no new evaluation, output stable
        run_op(32'd256, 1'b0, g, ov, np, ok);
        chk("hold_done0", 64'(ok), 64'd1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("hold_done", 64'(grad_done), 64'd1);
            chk("hold_fstart", 64'(func_start), 64'd0);
            chk("hold_grad", grad_out, 64'd1536);
        end
        start_grad = 1'b0;
        @(negedge clk);
        chk("hold_release", 64'(grad_done), 64'd0);
        run_op(-32'sd512, 1'b0, g, ov, np, ok);
        chk("rerun_grad", g, 64'd0);
        chk("rerun_pulses", 64'(np), 64'd2);
        start_grad = 1'b0;
        @(negedge clk);

        // start_grad dropped early: operation completes, 1-cycle done pulse
        @(negedge clk);
        x_in = 32'd0; start_grad = 1'b1;
        repeat (2) @(negedge clk);
        start_grad = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (grad_done) begin ok = 1'b1; break; end
        end
        chk("early_done", 64'(ok), 64'd1);
        chk("early_grad", grad_out, 64'd1024);
        @(negedge clk);
        chk("early_pulse_w", 64'(grad_done), 64'd0);

        // Reset during EVAL_M, then a clean run
        @(negedge clk);
        x_in = 32'd256; start_grad = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (func_start && func_x == 32'sd240) begin ok = 1'b1; break; end
        end
        chk("reach_eval_m", 64'(ok), 64'd1);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_fstart", 64'(func_start), 64'd0);
        chk("mid_rst_fx", 64'(func_x), 64'd0);
        chk("mid_rst_grad", grad_out, 64'd0);
        chk("mid_rst_done", 64'(grad_done), 64'd0);
        @(negedge clk);
        start_grad = 1'b0;
        rst = 1'b0;
        repeat (10) @(negedge clk);
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (!func_done && ev_st == 0) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        chk("ev_idle", 64'(ok), 64'd1);
        run_op(32'd256, 1'b0, g, ov, np, ok);
        chk("post_rst_done", 64'(ok), 64'd1);
        chk("post_rst_grad", g, 64'd1536);
        chk("post_rst_ovf", 64'(ov), 64'd0);
        start_grad = 1'b0;
        repeat (3) @(negedge clk);

        chk("protocol", 64'(viol), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
